// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module : dmem_arb_pkg
// Brief  : Shared types and defaults for the data-memory port arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_M0   = 2'd1,
        OWN_M1   = 2'd2
    } owner_e;

    localparam int DEF_MAX_BURST = 4;

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module : rr_arb2
// Brief  : Two-way round-robin grant with bounded lock; computes next owner/burst.
// Rev    : 1.0 - initial release
// ============================================================================
module rr_arb2
    import dmem_arb_pkg::*;
#(
    parameter  int MAX_BURST = DEF_MAX_BURST,
    localparam int CNT_W     = $clog2(MAX_BURST + 1)
) (
    input  logic [1:0]       req_i,
    input  logic [1:0]       lock_i,
    input  logic [1:0]       owner_i,
    input  logic [CNT_W-1:0] burst_i,
    output logic [1:0]       gnt_o,
    output logic [1:0]       owner_d_o,
    output logic [CNT_W-1:0] burst_d_o
);

    localparam logic [CNT_W-1:0] C_MAX = CNT_W'(MAX_BURST);

    owner_e     w_owner;
    owner_e     w_new_owner;
    logic       w_hold0;
    logic       w_hold1;

    assign w_owner = owner_e'(owner_i);

    // A lock only counts for the requester that already owns the port.
    assign w_hold0 = (w_owner == OWN_M0) && lock_i[0] && (burst_i < C_MAX);
    assign w_hold1 = (w_owner == OWN_M1) && lock_i[1] && (burst_i < C_MAX);

    always_comb begin
        gnt_o = 2'b00;
        unique case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11: begin
                if (w_hold0) begin
                    gnt_o = 2'b01;
                end else if (w_hold1) begin
                    gnt_o = 2'b10;
                end else if (w_owner == OWN_M0) begin
                    gnt_o = 2'b10;
                end else begin
                    gnt_o = 2'b01;
                end
            end
            default: gnt_o = 2'b00;
        endcase
    end

    always_comb begin
        owner_d_o   = owner_i;
        burst_d_o   = '0;
        w_new_owner = gnt_o[0] ? OWN_M0 : OWN_M1;
        if (gnt_o != 2'b00) begin
            if (w_new_owner == w_owner) begin
                burst_d_o = (burst_i == C_MAX) ? burst_i : burst_i + CNT_W'(1);
            end else begin
                owner_d_o = w_new_owner;
                burst_d_o = CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module : dmem_arbiter
// Brief  : Shares one data-memory port between the CPU (m0) and a loader (m1).
// Rev    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter  int BITNESS   = 32,
    parameter  int MAX_BURST = DEF_MAX_BURST,
    localparam int CNT_W     = $clog2(MAX_BURST + 1)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               m0_req_i,
    input  logic               m0_lock_i,
    input  logic               m0_we_i,
    input  logic [BITNESS-1:0] m0_addr_i,
    input  logic [BITNESS-1:0] m0_wdata_i,
    input  logic [2:0]         m0_funct3_i,
    output logic               m0_gnt_o,
    output logic               m0_rvalid_o,
    output logic [BITNESS-1:0] m0_rdata_o,
    input  logic               m1_req_i,
    input  logic               m1_lock_i,
    input  logic               m1_we_i,
    input  logic [BITNESS-1:0] m1_addr_i,
    input  logic [BITNESS-1:0] m1_wdata_i,
    input  logic [2:0]         m1_funct3_i,
    output logic               m1_gnt_o,
    output logic               m1_rvalid_o,
    output logic [BITNESS-1:0] m1_rdata_o,
    output logic               mem_we_o,
    output logic [BITNESS-1:0] mem_addr_o,
    output logic [BITNESS-1:0] mem_wdata_o,
    output logic [2:0]         mem_funct3_o,
    input  logic [BITNESS-1:0] mem_rdata_i,
    output logic               cpu_stall_o
);

    logic [1:0]         owner_q;
    logic [1:0]         owner_d;
    logic [CNT_W-1:0]   burst_q;
    logic [CNT_W-1:0]   burst_d;
    logic               rvalid0_q;
    logic               rvalid0_d;
    logic               rvalid1_q;
    logic               rvalid1_d;
    logic [BITNESS-1:0] rdata_q;
    logic [BITNESS-1:0] rdata_d;

    logic [1:0]         w_req;
    logic [1:0]         w_gnt;

    // Requests are masked during reset so no access (and no write) is issued.
    assign w_req = {m1_req_i, m0_req_i} & {2{~rst_i}};

    rr_arb2 #(
        .MAX_BURST (MAX_BURST)
    ) u_rr_arb2 (
        .req_i     (w_req),
        .lock_i    ({m1_lock_i, m0_lock_i}),
        .owner_i   (owner_q),
        .burst_i   (burst_q),
        .gnt_o     (w_gnt),
        .owner_d_o (owner_d),
        .burst_d_o (burst_d)
    );

    always_comb begin
        mem_we_o     = 1'b0;
        mem_addr_o   = '0;
        mem_wdata_o  = '0;
        mem_funct3_o = 3'b000;
        if (w_gnt[0]) begin
            mem_we_o     = m0_we_i;
            mem_addr_o   = m0_addr_i;
            mem_wdata_o  = m0_wdata_i;
            mem_funct3_o = m0_funct3_i;
        end else if (w_gnt[1]) begin
            mem_we_o     = m1_we_i;
            mem_addr_o   = m1_addr_i;
            mem_wdata_o  = m1_wdata_i;
            mem_funct3_o = m1_funct3_i;
        end
    end

    assign rvalid0_d = w_gnt[0] & ~m0_we_i;
    assign rvalid1_d = w_gnt[1] & ~m1_we_i;
    assign rdata_d   = (rvalid0_d | rvalid1_d) ? mem_rdata_i : rdata_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            owner_q   <= OWN_NONE;
            burst_q   <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            owner_q   <= owner_d;
            burst_q   <= burst_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
            rdata_q   <= rdata_d;
        end
    end

    assign m0_gnt_o    = w_gnt[0];
    assign m1_gnt_o    = w_gnt[1];
    assign m0_rvalid_o = rvalid0_q;
    assign m1_rvalid_o = rvalid1_q;
    assign m0_rdata_o  = rdata_q;
    assign m1_rdata_o  = rdata_q;
    assign cpu_stall_o = m0_req_i & ~w_gnt[0];

endmodule
`default_nettype wire
